// File: rtl/end_screen_ctrl.sv
// End-of-game sequencer: freeze, fade, win overlay with blink, restart.
// Also the final registered pixel stage driving the VGA colour.
module end_screen_ctrl #(
    parameter int unsigned FREEZE_FRAMES   = 60,
    parameter int unsigned FADE_FRAMES     = 15,
    parameter int unsigned BLINK_FRAMES    = 30,
    parameter int unsigned MIN_SHOW_FRAMES = 90,
    parameter int unsigned TIMEOUT_FRAMES  = 600
) (
    input  logic        clk,
    input  logic        resetN,
    input  logic        startOfFrame,
    input  logic        gameEnded,
    input  logic        playerWon,
    input  logic        restartKey,
    input  logic [11:0] backgroundRGB,
    input  logic        win_screen_dr,
    input  logic [11:0] win_screen_RGB,
    output logic [11:0] RGBout,
    output logic        freezeGame,
    output logic        restartGame,
    output logic        showingEnd
);

    localparam logic [9:0] FREEZE_LAST  = 10'(FREEZE_FRAMES - 1);
    localparam logic [9:0] FADE_LAST    = 10'(FADE_FRAMES - 1);
    localparam logic [9:0] BLINK_LAST   = 10'(BLINK_FRAMES - 1);
    localparam logic [9:0] MIN_SHOW     = 10'(MIN_SHOW_FRAMES);
    localparam logic [9:0] TIMEOUT_LAST = 10'(TIMEOUT_FRAMES - 1);

    typedef enum logic [2:0] {
        S_PLAY,
        S_FREEZE,
        S_FADE,
        S_SHOW,
        S_RESTART,
        S_WAIT_REL
    } state_t;

    state_t      state_q, state_d;
    logic [9:0]  fcnt_q, fcnt_d;
    logic [9:0]  step_q, step_d;
    logic [9:0]  step_last;
    logic [1:0]  dim_q, dim_d;
    logic        blink_q, blink_d;
    logic        won_q, won_d;
    logic [11:0] rgb_q, rgb_d;
    logic [11:0] dimmed;
    logic        key_ok, timeout;

    always_comb begin
        state_d = state_q;
        dim_d   = dim_q;
        blink_d = blink_q;
        won_d   = won_q;
        key_ok  = restartKey && (fcnt_q >= MIN_SHOW);
        timeout = startOfFrame && (fcnt_q == TIMEOUT_LAST);

        unique case (state_q)
            S_PLAY: begin
                dim_d = 2'd0;
                if (gameEnded) begin
                    won_d   = playerWon;
                    state_d = S_FREEZE;
                end
            end
            S_FREEZE: begin
                dim_d = 2'd0;
                if (startOfFrame && fcnt_q == FREEZE_LAST)
                    state_d = S_FADE;
            end
            S_FADE: begin
                if (startOfFrame && step_q == FADE_LAST) begin
                    dim_d = (dim_q == 2'd2) ? dim_q : dim_q + 2'd1;
                    if (dim_d == 2'd2)
                        state_d = S_SHOW;
                end
            end
            S_SHOW: begin
                if (startOfFrame && step_q == BLINK_LAST)
                    blink_d = ~blink_q;
                if (key_ok || timeout)
                    state_d = S_RESTART;
            end
            S_RESTART: state_d = S_WAIT_REL;
            S_WAIT_REL: begin
                if (!restartKey && !gameEnded) begin
                    state_d = S_PLAY;
                    dim_d   = 2'd0;
                end
            end
            default: state_d = S_PLAY;
        endcase

        if (state_d == S_SHOW && state_q != S_SHOW)
            blink_d = 1'b1;
    end

    // step wraps per fade step or blink half-period; fcnt is time-in-state
    always_comb begin
        step_last = 10'd0;
        if (state_q == S_FADE)
            step_last = FADE_LAST;
        else if (state_q == S_SHOW)
            step_last = BLINK_LAST;

        fcnt_d = fcnt_q;
        step_d = step_q;
        if (state_d != state_q) begin
            fcnt_d = 10'd0;
            step_d = 10'd0;
        end else if (startOfFrame) begin
            fcnt_d = fcnt_q + 10'd1;
            step_d = (step_q == step_last) ? 10'd0 : step_q + 10'd1;
        end
    end

    always_comb begin
        dimmed = {backgroundRGB[11:8] >> dim_q,
                  backgroundRGB[7:4] >> dim_q,
                  backgroundRGB[3:0] >> dim_q};
        rgb_d  = dimmed;
        if (state_q == S_SHOW && won_q && blink_q && win_screen_dr)
            rgb_d = win_screen_RGB;
    end

    always_ff @(posedge clk or negedge resetN) begin
        if (!resetN) begin
            state_q <= S_PLAY;
            fcnt_q  <= 10'd0;
            step_q  <= 10'd0;
            dim_q   <= 2'd0;
            blink_q <= 1'b1;
            won_q   <= 1'b0;
            rgb_q   <= 12'h000;
        end else begin
            state_q <= state_d;
            fcnt_q  <= fcnt_d;
            step_q  <= step_d;
            dim_q   <= dim_d;
            blink_q <= blink_d;
            won_q   <= won_d;
            rgb_q   <= rgb_d;
        end
    end

    assign RGBout      = rgb_q;
    assign freezeGame  = (state_q != S_PLAY);
    assign restartGame = (state_q == S_RESTART);
    assign showingEnd  = state_q inside {S_FADE, S_SHOW, S_RESTART};

endmodule

// File: tb/tb_end_screen_ctrl.sv
// Bench for end_screen_ctrl: frame-count reference model feeding a
// scoreboard queue, plus directed checks along the end-screen sequence.
module tb_end_screen_ctrl;

    localparam int FREEZE = 60;
    localparam int FADE   = 15;
    localparam int BLINK  = 30;
    localparam int MINS   = 90;
    localparam int TOUT   = 600;

    localparam int P_PLAY    = 0;
    localparam int P_FREEZE  = 1;
    localparam int P_FADE    = 2;
    localparam int P_SHOW    = 3;
    localparam int P_RESTART = 4;
    localparam int P_WAIT    = 5;

    logic        clk = 1'b0;
    logic        resetN = 1'b1;
    logic        sof = 1'b0;
    logic        ge = 1'b0;
    logic        pw = 1'b0;
    logic        key = 1'b0;
    logic        dr = 1'b0;
    logic [11:0] bg = 12'h000;
    logic [11:0] wrgb = 12'h000;
    logic [11:0] rgb;
    logic        frz, rst, shw;

    int checks = 0;
    int errors = 0;
    int pulses = 0;
    int gap = 0;

    logic        fix_en = 1'b0;
    logic [11:0] fix_bg = 12'h000;
    logic        fix_dr = 1'b0;
    logic [11:0] fix_wrgb = 12'h000;

    typedef struct packed {
        logic [11:0] rgb;
        logic        frz;
        logic        rst;
        logic        shw;
    } exp_t;

    exp_t q[$];

    int   m_phase = P_PLAY;
    int   m_frm = 0;
    logic m_won = 1'b0;

    always #5 clk = ~clk;

    end_screen_ctrl dut (
        .clk           (clk),
        .resetN        (resetN),
        .startOfFrame  (sof),
        .gameEnded     (ge),
        .playerWon     (pw),
        .restartKey    (key),
        .backgroundRGB (bg),
        .win_screen_dr (dr),
        .win_screen_RGB(wrgb),
        .RGBout        (rgb),
        .freezeGame    (frz),
        .restartGame   (rst),
        .showingEnd    (shw)
    );

    task automatic chk(input string name, input logic [11:0] act,
                       input logic [11:0] expv);
        checks++;
        if (act !== expv) begin
            errors++;
            $display("FAIL %s: got %h expected %h at %0t",
                     name, act, expv, $time);
        end
    endtask

    // Brightness level as a function of frames spent in the phase
    function automatic int model_dim(input int ph, input int frm);
        if (ph == P_FADE)
            return frm / FADE;
        if (ph == P_SHOW || ph == P_RESTART || ph == P_WAIT)
            return 2;
        return 0;
    endfunction

    function automatic logic [11:0] dim_pix(input logic [11:0] p,
                                            input int d);
        int div;
        div = 1 << d;
        return {4'(int'(p[11:8]) / div),
                4'(int'(p[7:4]) / div),
                4'(int'(p[3:0]) / div)};
    endfunction

    always @(posedge clk) begin
        exp_t e;
        int   nph;
        int   nfrm;
        logic nwon;
        logic blink;
        if (!resetN) begin
            e = '0;
            q.push_back(e);
            m_phase <= P_PLAY;
            m_frm   <= 0;
            m_won   <= 1'b0;
        end else begin
            blink = ((m_frm / BLINK) % 2) == 0;
            if (m_phase == P_SHOW && m_won && blink && dr)
                e.rgb = wrgb;
            else
                e.rgb = dim_pix(bg, model_dim(m_phase, m_frm));
            nph  = m_phase;
            nfrm = sof ? m_frm + 1 : m_frm;
            nwon = m_won;
            case (m_phase)
                P_PLAY:
                    if (ge) begin
                        nph  = P_FREEZE;
                        nwon = pw;
                    end
                P_FREEZE:
                    if (sof && m_frm + 1 == FREEZE) nph = P_FADE;
                P_FADE:
                    if (sof && m_frm + 1 == 2 * FADE) nph = P_SHOW;
                P_SHOW:
                    if ((key && m_frm >= MINS) ||
                        (sof && m_frm + 1 == TOUT))
                        nph = P_RESTART;
                P_RESTART:
                    nph = P_WAIT;
                default:
                    if (!key && !ge) nph = P_PLAY;
            endcase
            if (nph != m_phase)
                nfrm = 0;
            e.frz = (nph != P_PLAY);
            e.rst = (nph == P_RESTART);
            e.shw = (nph == P_FADE || nph == P_SHOW || nph == P_RESTART);
            q.push_back(e);
            m_phase <= nph;
            m_frm   <= nfrm;
            m_won   <= nwon;
        end
    end

    always @(posedge clk) begin
        exp_t e;
        #1;
        if (rst === 1'b1)
            pulses++;
        if (q.size() == 0) begin
            checks++;
            errors++;
            $display("FAIL scoreboard_empty: got none expected entry at %0t",
                     $time);
        end else begin
            e = q.pop_front();
            chk("sb_RGBout", rgb, e.rgb);
            chk("sb_freezeGame", 12'(frz), 12'(e.frz));
            chk("sb_restartGame", 12'(rst), 12'(e.rst));
            chk("sb_showingEnd", 12'(shw), 12'(e.shw));
        end
    end

    task automatic tick();
        if (fix_en) begin
            bg   = fix_bg;
            dr   = fix_dr;
            wrgb = fix_wrgb;
        end else begin
            bg   = 12'($urandom);
            dr   = 1'($urandom);
            wrgb = 12'($urandom);
        end
        if (gap == 0) begin
            sof = 1'b1;
            gap = int'($urandom_range(1, 4));
        end else begin
            sof = 1'b0;
            gap--;
        end
        @(negedge clk);
    endtask

    task automatic wait_for(input int ph, input int frm, input string tag);
        int n;
        n = 0;
        while (!(m_phase == ph && m_frm == frm) && n < 20000) begin
            tick();
            n++;
        end
        if (n >= 20000) begin
            checks++;
            errors++;
            $display("FAIL wait_%s: got phase %0d frame %0d expected %0d/%0d",
                     tag, m_phase, m_frm, ph, frm);
        end
    endtask

    initial begin
        #5_000_000;
        $display("FAIL watchdog: got no finish expected finish");
        $fatal(1, "watchdog expired");
    end

    initial begin
        int p0;
        int n;

        #1 resetN = 1'b0;
        #1;
        chk("reset_RGBout", rgb, 12'h000);
        chk("reset_freeze", 12'(frz), 12'h0);
        chk("reset_restart", 12'(rst), 12'h0);
        chk("reset_showing", 12'(shw), 12'h0);
        @(negedge clk);
        repeat (3) tick();
        resetN = 1'b1;

        // Pass-through in PLAY
        fix_en   = 1'b1;
        fix_bg   = 12'hABC;
        fix_dr   = 1'b1;
        fix_wrgb = 12'hF00;
        repeat (2) tick();
        chk("play_passthru", rgb, 12'hABC);
        chk("play_freeze", 12'(frz), 12'h0);

        // Win sequence
        fix_bg = 12'hFFF;
        ge = 1'b1;
        pw = 1'b1;
        tick();
        pw = 1'b0;
        wait_for(P_FREEZE, 5, "freeze5");
        ge = 1'b0;
        wait_for(P_FREEZE, 30, "freeze30");
        tick();
        chk("freeze_undimmed", rgb, 12'hFFF);
        chk("freeze_hold", 12'(frz), 12'h1);
        wait_for(P_FADE, 20, "fade20");
        tick();
        chk("fade_step1", rgb, 12'h777);
        chk("fade_showing", 12'(shw), 12'h1);
        wait_for(P_SHOW, 2, "show2");
        fix_dr = 1'b0;
        tick();
        chk("show_dim2", rgb, 12'h333);
        fix_dr = 1'b1;
        wait_for(P_SHOW, 10, "show10");
        key = 1'b1;
        tick();
        key = 1'b0;
        chk("overlay_on", rgb, 12'hF00);
        chk("early_key_ignored", 12'(rst), 12'h0);
        wait_for(P_SHOW, 40, "show40");
        tick();
        chk("blink_off", rgb, 12'h333);
        wait_for(P_SHOW, 60, "show60");
        tick();
        chk("blink_on_again", rgb, 12'hF00);
        wait_for(P_SHOW, 90, "show90");
        p0  = pulses;
        key = 1'b1;
        ge  = 1'b1;
        tick();
        chk("key_restart", 12'(rst), 12'h1);
        repeat (20) tick();
        chk("wait_rel_freeze", 12'(frz), 12'h1);
        chk("wait_rel_showing", 12'(shw), 12'h0);
        chk("key_single_pulse", 12'(pulses - p0), 12'h1);
        key    = 1'b0;
        ge     = 1'b0;
        fix_bg = 12'h5A3;
        repeat (3) tick();
        chk("release_freeze", 12'(frz), 12'h0);
        chk("release_undimmed", rgb, 12'h5A3);

        // Loss sequence: no overlay, timeout restart
        fix_bg = 12'hFFF;
        ge = 1'b1;
        pw = 1'b0;
        tick();
        ge = 1'b0;
        pw = 1'b1;
        wait_for(P_SHOW, 10, "loss_show10");
        tick();
        chk("loss_no_overlay", rgb, 12'h333);
        wait_for(P_SHOW, 599, "loss_show599");
        p0 = pulses;
        n  = 0;
        while (pulses == p0 && n < 50) begin
            tick();
            n++;
        end
        repeat (10) tick();
        chk("timeout_single_pulse", 12'(pulses - p0), 12'h1);
        chk("timeout_back_play", 12'(frz), 12'h0);

        // Reset during FADE
        fix_en = 1'b0;
        ge = 1'b1;
        pw = 1'b1;
        tick();
        wait_for(P_FADE, 5, "fade5");
        ge = 1'b0;
        p0 = pulses;
        #2 resetN = 1'b0;
        #1;
        chk("async_rst_RGBout", rgb, 12'h000);
        chk("async_rst_freeze", 12'(frz), 12'h0);
        chk("async_rst_restart", 12'(rst), 12'h0);
        @(negedge clk);
        repeat (2) tick();
        resetN = 1'b1;
        repeat (4) tick();
        chk("post_reset_freeze", 12'(frz), 12'h0);
        chk("post_reset_showing", 12'(shw), 12'h0);
        chk("post_reset_no_pulse", 12'(pulses - p0), 12'h0);

        // Random soak against the model
        for (int r = 0; r < 3; r++) begin
            for (int i = 0; i < 4000; i++) begin
                if ($urandom_range(0, 299) == 0)
                    ge = ~ge;
                pw  = 1'($urandom);
                key = ($urandom_range(0, 39) == 0);
                tick();
            end
        end
        key = 1'b0;
        ge  = 1'b0;
        repeat (4) tick();

        $display("Simulation finished: %0d checks, %0d errors",
                 checks, errors);
        $finish;
    end

endmodule
